// File: rtl/regfile_write_demux.sv
// regfile_write_demux: 32x32 register file fed through a FIFO write queue with a one-hot write decoder.
// Optional WRITE_BYPASS_EN overlays queued writes onto RegisterBank; the default build shows committed contents only.
module regfile_write_demux #(
  parameter int QUEUE_DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          WriteEnable,
  input  logic [4:0]    WriteRegister,
  input  logic [31:0]   WriteData,
  output logic          WriteReady,
  input  logic          CommitHold,
  output logic [2:0]    QueueCount,
  output logic [1023:0] RegisterBank
);
  localparam int PW = $clog2(QUEUE_DEPTH);
  typedef logic [PW-1:0] ptr_t;
  logic [4:0]        qreg_q [QUEUE_DEPTH];
  logic [31:0]       qdata_q [QUEUE_DEPTH];
  ptr_t              head_q, tail_q;
  logic [2:0]        count_q, count_d;
  logic [31:0][31:0] regs_q, bank;
  logic [31:0]       wen;
  logic              push, pop;
  assign WriteReady = count_q < 3'(QUEUE_DEPTH);
  assign push       = WriteEnable && WriteReady;
  assign pop        = (count_q != 3'd0) && !CommitHold;
  assign count_d    = count_q + 3'(push) - 3'(pop);
  // Register 0 is masked out of the decoder so it stays hard-wired to zero.
  assign wen        = pop ? ((32'd1 << qreg_q[head_q]) & ~32'd1) : 32'd0;
  assign QueueCount = count_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      regs_q  <= '0;
    end else begin
      if (push) begin
        qreg_q[tail_q]  <= WriteRegister;
        qdata_q[tail_q] <= WriteData;
        tail_q          <= tail_q + ptr_t'(1);
      end
      if (pop) head_q <= head_q + ptr_t'(1);
      count_q <= count_d;
      for (int k = 0; k < 32; k++)
        if (wen[k]) regs_q[k] <= qdata_q[head_q];
    end
  end
`ifdef WRITE_BYPASS_EN
  ptr_t idx;
  // Walk oldest to youngest so the youngest queued write to a register wins.
  always_comb begin
    bank = regs_q;
    idx  = head_q;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      idx = head_q + ptr_t'(i);
      if (3'(i) < count_q && qreg_q[idx] != 5'd0) bank[qreg_q[idx]] = qdata_q[idx];
    end
  end
`else
  always_comb begin
    bank = regs_q;
  end
`endif
  assign RegisterBank = bank;
endmodule

// File: tb/tb_regfile_write_demux.sv
// tb_regfile_write_demux: directed and random checks against a queue-based reference model.
module tb_regfile_write_demux;
  localparam int D = 2;
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          WriteEnable = 1'b0;
  logic [4:0]    WriteRegister = '0;
  logic [31:0]   WriteData = '0;
  logic          CommitHold = 1'b0;
  logic          WriteReady;
  logic [2:0]    QueueCount;
  logic [1023:0] RegisterBank;
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] m [32];
  logic [36:0] q [$];

  regfile_write_demux #(.QUEUE_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .WriteEnable(WriteEnable), .WriteRegister(WriteRegister),
    .WriteData(WriteData), .WriteReady(WriteReady), .CommitHold(CommitHold),
    .QueueCount(QueueCount), .RegisterBank(RegisterBank)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1023:0] exp_bank();
    logic [1023:0] b;
    for (int r = 0; r < 32; r++) b[32*r +: 32] = m[r];
`ifdef WRITE_BYPASS_EN
    foreach (q[i]) if (q[i][36:32] != 5'd0) b[32*q[i][36:32] +: 32] = q[i][31:0];
`endif
    return b;
  endfunction

  function automatic logic [31:0] rd(input int r);
    return RegisterBank[32*r +: 32];
  endfunction

  task automatic step(input bit r, input bit e, input logic [4:0] a, input logic [31:0] d, input bit h);
    logic [36:0] ent;
    bit acc;
    @(negedge clk);
    reset = r; WriteEnable = e; WriteRegister = a; WriteData = d; CommitHold = h;
    #1;
    chk("ready", 1024'(WriteReady), 1024'(q.size() < D));
    @(posedge clk);
    if (r) begin
      q.delete();
      for (int k = 0; k < 32; k++) m[k] = '0;
    end else begin
      acc = e && (q.size() < D);
      if (q.size() > 0 && !h) begin
        ent = q.pop_front();
        if (ent[36:32] != 5'd0) m[ent[36:32]] = ent[31:0];
      end
      if (acc) q.push_back({a, d});
    end
    #1;
    chk("count", 1024'(QueueCount), 1024'(q.size()));
    chk("bank", RegisterBank, exp_bank());
  endtask

  initial begin
    for (int k = 0; k < 32; k++) m[k] = '0;
    step(1, 0, 0, 0, 0);
    step(1, 1, 3, 32'h1234, 0);
    chk("rst_bank", RegisterBank, '0);
    chk("rst_cnt", 1024'(QueueCount), 0);
    chk("rst_rdy", 1024'(WriteReady), 1);
    // single write latency
    step(0, 1, 5, 32'hDEADBEEF, 0);
    chk("lat_cnt1", 1024'(QueueCount), 1);
    step(0, 0, 0, 0, 0);
    chk("lat_r5", 1024'(rd(5)), 1024'(32'hDEADBEEF));
    chk("lat_cnt0", 1024'(QueueCount), 0);
    // hold fills queue, third write held, release drains in order
    step(0, 1, 1, 11, 1);
    step(0, 1, 2, 22, 1);
    chk("full_rdy", 1024'(WriteReady), 0);
    step(0, 1, 3, 33, 1);
    chk("full_cnt", 1024'(QueueCount), 2);
    step(0, 1, 3, 33, 0);
    chk("ord_r1", 1024'(rd(1)), 11);
    step(0, 1, 3, 33, 0);
    chk("ord_r2", 1024'(rd(2)), 22);
    step(0, 0, 0, 0, 0);
    chk("ord_r3", 1024'(rd(3)), 33);
    // register 0 writes are queued but discarded
    step(0, 1, 0, 32'hFFFFFFFF, 0);
    chk("r0_cnt1", 1024'(QueueCount), 1);
    step(0, 0, 0, 0, 0);
    chk("r0_cnt0", 1024'(QueueCount), 0);
    chk("r0_val", 1024'(rd(0)), 0);
    // same register twice under hold
    step(0, 1, 7, 1, 1);
    step(0, 1, 7, 2, 1);
`ifdef WRITE_BYPASS_EN
    chk("r7_early", 1024'(rd(7)), 2);
`else
    chk("r7_early", 1024'(rd(7)), 0);
`endif
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("r7_final", 1024'(rd(7)), 2);
    // reset with a full queue discards everything
    step(0, 1, 9, 32'hAAAA, 1);
    step(0, 1, 10, 32'hBBBB, 1);
    step(1, 1, 11, 32'hCCCC, 1);
    chk("rq_bank", RegisterBank, '0);
    chk("rq_cnt", 1024'(QueueCount), 0);
    chk("rq_rdy", 1024'(WriteReady), 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("rq_late", RegisterBank, '0);
    // streaming writes at full rate
    for (int r = 1; r < 32; r++) begin
      step(0, 1, 5'(r), $urandom, 0);
      chk("str_cnt", 1024'(QueueCount), 1);
    end
    step(0, 0, 0, 0, 0);
    // random traffic
    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 7, 5'($urandom),
           $urandom, $urandom_range(0, 9) < 3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_write_demux.md
REGFILE_WRITE_DEMUX -- requirements
Module: regfile_write_demux

Interface
REQ-001 Parameter QUEUE_DEPTH, default 2; number of write-queue entries; legal values 2 or 4.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 WriteEnable  input  1  write request valid.
REQ-005 WriteRegister  input  5  destination register address.
REQ-006 WriteData  input  32  write-back data.
REQ-007 WriteReady  output  1  queue can accept; high = not full.
REQ-008 CommitHold  input  1  when high, freezes queue drain (array not updated).
REQ-009 QueueCount  output  3  current queue occupancy, 0..QUEUE_DEPTH.
REQ-010 RegisterBank  output  1024  register contents, register k on bits [32k+31:32k], feeds the 32x32 read mux inputs directly.

Function
REQ-011 Block SHALL hold 32 registers of 32 bits and write them via a 5-to-32 decoded one-hot enable, the write-side counterpart of the register read mux.
REQ-012 Accept occurs on a rising edge where WriteEnable=1 and WriteReady=1; {WriteRegister, WriteData} SHALL be pushed to the queue tail.
REQ-013 WriteReady SHALL be combinational: 1 iff QueueCount < QUEUE_DEPTH; a request with WriteReady=0 SHALL be ignored (no push, no error); the requester holds it.
REQ-014 Drain: on each edge where QueueCount>0 and CommitHold=0, the head entry SHALL be written into the array and popped.
REQ-015 Latency: with empty queue and CommitHold=0, a write accepted at edge N SHALL commit at edge N+1 and appear on RegisterBank after edge N+1.
REQ-016 Throughput: one accept and one commit per cycle; simultaneous push and pop SHALL leave QueueCount unchanged.
REQ-017 When full, WriteReady SHALL be 0 even if a pop occurs in the same cycle (no same-cycle fall-through).
REQ-018 Queue order SHALL be strict FIFO; two queued writes to the same register SHALL leave the later value.
REQ-019 Writes to register 0 SHALL be accepted and queued but SHALL NOT modify the array; RegisterBank[31:0] SHALL always read 0.
REQ-020 Queue pointers SHALL wrap modulo QUEUE_DEPTH; QueueCount SHALL never exceed QUEUE_DEPTH nor go below 0.
REQ-021 CommitHold=1 SHALL not block accepts while the queue is not full.
REQ-022 Unselected registers SHALL hold value on every edge.

Reset
REQ-023 On an edge with reset=1: all 32 registers SHALL become 0, queue SHALL empty (QueueCount=0, WriteReady=1), pointers to 0.
REQ-024 Reset SHALL take priority over accept and drain; writes pending or presented at that edge SHALL be discarded.
REQ-025 Reset mid-operation SHALL leave no partially committed entry; first accept after reset follows REQ-015.

Configuration
REQ-026 Macro WRITE_BYPASS_EN: when defined, RegisterBank SHALL overlay queued (uncommitted) writes on committed values, youngest entry winning per register, register 0 excluded; combinational, same cycle as accept edge.
REQ-027 Without WRITE_BYPASS_EN, RegisterBank SHALL show committed array contents only.

Verification
REQ-028 Reset, then WriteEnable=1, WriteRegister=5, WriteData=32'hDEADBEEF for one cycle -> QueueCount 1 after edge N, register 5 = DEADBEEF after edge N+1, QueueCount 0.
REQ-029 CommitHold=1, three back-to-back writes (regs 1,2,3 = 11,22,33), QUEUE_DEPTH=2 -> WriteReady 0 after second accept, third held; release hold -> commits in order 1,2,3 over three edges.
REQ-030 Write register 0 = 32'hFFFFFFFF -> accepted, QueueCount 1 then 0, RegisterBank[31:0] stays 0.
REQ-031 Hold asserted, queue reg 7 = 1 then reg 7 = 2, release -> register 7 ends 2; with WRITE_BYPASS_EN, register 7 reads 2 immediately after second accept; without it, reads 0 until commits.
REQ-032 Full queue (2 entries, hold on), assert reset with WriteEnable=1 -> after edge all registers 0, QueueCount 0, WriteReady 1, no later commit of discarded entries.
REQ-033 Continuous writes to regs 1..31 at one per cycle, hold low -> QueueCount stays 1, WriteReady never drops, all 31 registers match after final commit.
